// File: rtl/branch_predictor_if.sv
// IF-stage direct-mapped branch predictor: zero-latency lookup of the fetch PC,
// IF/ID copy of the prediction, and 2-bit counter training from resolved branches in ID.
module branch_predictor_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_if,
    input  logic            stall,
    input  logic            flush,
    output logic            pred_taken_if,
    output logic [XLEN-1:0] pred_target_if,
    output logic            pred_taken_id,
    output logic [XLEN-1:0] pred_target_id,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int unsigned Entries = 2 ** INDEX_BITS;
    localparam int unsigned TagBits = XLEN - INDEX_BITS - 2;

    logic               valid_q  [Entries];
    logic [TagBits-1:0] tag_q    [Entries];
    logic [XLEN-1:0]    target_q [Entries];
    logic [1:0]         ctr_q    [Entries];

    logic [INDEX_BITS-1:0] if_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TagBits-1:0]    if_tag;
    logic [TagBits-1:0]    upd_tag;
    logic                  if_hit;
    logic                  upd_hit;

    assign if_idx  = pc_if[INDEX_BITS+1:2];
    assign if_tag  = pc_if[XLEN-1:INDEX_BITS+2];
    assign upd_idx = upd_pc[INDEX_BITS+1:2];
    assign upd_tag = upd_pc[XLEN-1:INDEX_BITS+2];

    // Lookup sees pre-update state; a same-cycle update shows up next cycle.
    always_comb begin
        if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        upd_hit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        pred_taken_if  = if_hit && ctr_q[if_idx][1];
        pred_target_if = pred_taken_if ? target_q[if_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Entries; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_en && !stall) begin
            // A stalled branch re-resolves once the stall clears, so it trains only then.
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                    end
                    target_q[upd_idx] <= upd_target;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pred_taken_id  <= 1'b0;
            pred_target_id <= '0;
        end else if (!stall) begin
            pred_taken_id  <= pred_taken_if;
            pred_target_id <= pred_target_if;
        end
    end

endmodule

// File: tb/tb_branch_predictor_if.sv
// Bench for branch_predictor_if: directed vector table for the trained corner cases,
// then randomized traffic checked against a table-of-records reference model.
module tb_branch_predictor_if;

    logic        clk;
    logic        rst;
    logic [31:0] pc_if;
    logic        stall;
    logic        flush;
    logic        pred_taken_if;
    logic [31:0] pred_target_if;
    logic        pred_taken_id;
    logic [31:0] pred_target_id;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    branch_predictor_if #(
        .XLEN       (32),
        .INDEX_BITS (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_if          (pc_if),
        .stall          (stall),
        .flush          (flush),
        .pred_taken_if  (pred_taken_if),
        .pred_target_if (pred_target_if),
        .pred_taken_id  (pred_taken_id),
        .pred_target_id (pred_target_id),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        upd_en;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic        e_tk_if;
        logic [31:0] e_tg_if;
        logic        e_tk_id;
        logic [31:0] e_tg_id;
    } vec_t;

    // Reference model: one record per table slot, confidence kept as a plain clamped int.
    typedef struct {
        bit        valid;
        bit [25:0] tag;
        bit [31:0] target;
        int        strength;
    } m_ent_t;

    m_ent_t      mtab [16];
    bit          m_tk_id;
    bit   [31:0] m_tg_id;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(logic r, logic [31:0] pc, logic st, logic fl, logic ue,
                                logic [31:0] up, logic ut, logic [31:0] ug,
                                logic etki, logic [31:0] etgi, logic etkd, logic [31:0] etgd);
        vec_t v;
        v.rst = r; v.pc = pc; v.stall = st; v.flush = fl;
        v.upd_en = ue; v.upd_pc = up; v.upd_taken = ut; v.upd_target = ug;
        v.e_tk_if = etki; v.e_tg_if = etgi; v.e_tk_id = etkd; v.e_tg_id = etgd;
        return v;
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got taken=%b target=%h, expected taken=%b target=%h",
                     name, act[32], act[31:0], exp[32], exp[31:0]);
        end
    endtask

    // Inputs applied just after a posedge; IF outputs sampled mid-cycle, ID outputs after the edge.
    task automatic drive_cycle(input vec_t v, output logic tk_if, output logic [31:0] tg_if,
                               output logic tk_id, output logic [31:0] tg_id);
        rst = v.rst; pc_if = v.pc; stall = v.stall; flush = v.flush;
        upd_en = v.upd_en; upd_pc = v.upd_pc; upd_taken = v.upd_taken;
        upd_target = v.upd_target;
        #4;
        tk_if = pred_taken_if;
        tg_if = pred_target_if;
        @(posedge clk);
        #1;
        tk_id = pred_taken_id;
        tg_id = pred_target_id;
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            mtab[i].valid = 0; mtab[i].tag = '0; mtab[i].target = '0; mtab[i].strength = 1;
        end
        m_tk_id = 0;
        m_tg_id = '0;
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output bit tk, output bit [31:0] tg);
        int idx;
        idx = (pc >> 2) % 16;
        tk  = mtab[idx].valid && (mtab[idx].tag == pc[31:6]) && (mtab[idx].strength >= 2);
        tg  = tk ? mtab[idx].target : 32'h0;
    endfunction

    function automatic void m_step(input vec_t v);
        bit        tk;
        bit [31:0] tg;
        int        idx;
        m_lookup(v.pc, tk, tg);
        if (v.rst) begin
            m_reset();
            return;
        end
        if (v.flush) begin
            m_tk_id = 0; m_tg_id = '0;
        end else if (!v.stall) begin
            m_tk_id = tk; m_tg_id = tg;
        end
        if (v.upd_en && !v.stall) begin
            idx = (v.upd_pc >> 2) % 16;
            if (mtab[idx].valid && mtab[idx].tag == v.upd_pc[31:6]) begin
                if (v.upd_taken) begin
                    mtab[idx].strength = (mtab[idx].strength < 3) ? mtab[idx].strength + 1 : 3;
                    mtab[idx].target   = v.upd_target;
                end else begin
                    mtab[idx].strength = (mtab[idx].strength > 0) ? mtab[idx].strength - 1 : 0;
                end
            end else if (v.upd_taken) begin
                mtab[idx].valid    = 1;
                mtab[idx].tag      = v.upd_pc[31:6];
                mtab[idx].target   = v.upd_target;
                mtab[idx].strength = 2;
            end
        end
    endfunction

    function automatic logic [31:0] rand_pc();
        return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    endfunction

    vec_t vecs[$];

    initial begin
        logic        tk_if;
        logic        tk_id;
        logic [31:0] tg_if;
        logic [31:0] tg_id;
        vec_t        v;
        bit          mtk;
        bit   [31:0] mtg;

        rst = 1; pc_if = 32'h100; stall = 0; flush = 0;
        upd_en = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        repeat (2) @(posedge clk);
        #1;

        //             rst pc      st fl ue upd_pc  ut upd_tgt   tk_if tg_if  tk_id tg_id
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 1, 32'h080, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mk(0, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 1, 32'h080, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 1, 32'h080, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 1, 32'h080, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 0, 32'h000, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 0, 32'h000, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 0, 32'h000, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 0, 32'h000, 0, 32'h000, 0, 32'h000));
        // Counter at 00: taken twice must climb 00->01->10, not wrap to 11.
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 1, 32'h080, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 1, 32'h080, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mk(0, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 1, 32'h080, 1, 32'h080));
        // Aliasing 0x140 onto index 0.
        vecs.push_back(mk(0, 32'h140, 0, 0, 1, 32'h140, 0, 32'h000, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mk(0, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(0, 32'h140, 0, 0, 1, 32'h140, 1, 32'h200, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mk(0, 32'h140, 0, 0, 0, 32'h000, 0, 32'h000, 1, 32'h200, 1, 32'h200));
        vecs.push_back(mk(0, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000));
        // Stall holds ID copy and blocks training; flush with stall clears.
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 1, 32'h080, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mk(0, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(0, 32'h100, 1, 0, 1, 32'h100, 0, 32'h000, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(0, 32'h100, 1, 0, 1, 32'h100, 0, 32'h000, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(0, 32'h100, 1, 0, 1, 32'h100, 0, 32'h000, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(0, 32'h100, 1, 1, 1, 32'h100, 0, 32'h000, 1, 32'h080, 0, 32'h000));
        // Same-cycle lookup and not-taken update: old prediction now, new one next cycle.
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 0, 32'h000, 1, 32'h080, 1, 32'h080));
        vecs.push_back(mk(0, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mk(0, 32'h100, 0, 0, 1, 32'h100, 1, 32'h080, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mk(0, 32'h100, 0, 1, 0, 32'h000, 0, 32'h000, 1, 32'h080, 0, 32'h000));
        // Mid-run reset overrides a taken update and wipes the table.
        vecs.push_back(mk(1, 32'h100, 0, 0, 1, 32'h100, 1, 32'h080, 1, 32'h080, 0, 32'h000));
        vecs.push_back(mk(0, 32'h100, 0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h000));
        // pc[1:0] are ignored for both update and lookup.
        vecs.push_back(mk(0, 32'h101, 0, 0, 1, 32'h103, 1, 32'h044, 0, 32'h000, 0, 32'h000));
        vecs.push_back(mk(0, 32'h102, 0, 0, 0, 32'h000, 0, 32'h000, 1, 32'h044, 1, 32'h044));

        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i], tk_if, tg_if, tk_id, tg_id);
            check($sformatf("vec%0d_if", i), {tk_if, tg_if}, {vecs[i].e_tk_if, vecs[i].e_tg_if});
            check($sformatf("vec%0d_id", i), {tk_id, tg_id}, {vecs[i].e_tk_id, vecs[i].e_tg_id});
        end

        v = mk(1, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        drive_cycle(v, tk_if, tg_if, tk_id, tg_id);
        m_reset();

        for (int n = 0; n < 3000; n++) begin
            v.rst        = ($urandom_range(0, 99) == 0);
            v.pc         = rand_pc();
            v.stall      = ($urandom_range(0, 3) == 0);
            v.flush      = ($urandom_range(0, 7) == 0);
            v.upd_en     = ($urandom_range(0, 1) == 0);
            v.upd_pc     = ($urandom_range(0, 2) == 0) ? v.pc : rand_pc();
            v.upd_taken  = ($urandom_range(0, 2) != 0);
            v.upd_target = $urandom;
            m_lookup(v.pc, mtk, mtg);
            drive_cycle(v, tk_if, tg_if, tk_id, tg_id);
            m_step(v);
            check($sformatf("rand%0d_if", n), {tk_if, tg_if}, {mtk, mtg});
            check($sformatf("rand%0d_id", n), {tk_id, tg_id}, {m_tk_id, m_tg_id});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
